// File: rtl/ctrl_pkg.sv
// Shared encodings for cpu_controller: state codes, instruction fields and strobe values.
// Branch-related encodings are only consumed when CTRL_BRANCH_EN is defined.
package ctrl_pkg;

   typedef logic [4:0] state_t;

   localparam state_t S_RST      = 5'd0;
   localparam state_t S_IF1      = 5'd1;
   localparam state_t S_IF2      = 5'd2;
   localparam state_t S_UPD_PC   = 5'd3;
   localparam state_t S_DECODE   = 5'd4;
   localparam state_t S_WR_IMM   = 5'd5;
   localparam state_t S_GET_A    = 5'd6;
   localparam state_t S_GET_B    = 5'd7;
   localparam state_t S_EXEC     = 5'd8;
   localparam state_t S_WR_REG   = 5'd9;
   localparam state_t S_EXEC_CMP = 5'd10;
   localparam state_t S_MEM_ADDR = 5'd11;
   localparam state_t S_LD_ADDR  = 5'd12;
   localparam state_t S_MEM_RD   = 5'd13;
   localparam state_t S_MEM_WB   = 5'd14;
   localparam state_t S_STR_RD   = 5'd15;
   localparam state_t S_STR_PASS = 5'd16;
   localparam state_t S_STR_WR   = 5'd17;
   localparam state_t S_HALT     = 5'd18;
   localparam state_t S_BR_TAKE  = 5'd19;
   localparam state_t S_BL_LINK  = 5'd20;
   localparam state_t S_BX_GET   = 5'd21;
   localparam state_t S_BX_PASS  = 5'd22;
   localparam state_t S_BX_LOAD  = 5'd23;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;
   localparam logic [2:0] OPC_B    = 3'b001;
   localparam logic [2:0] OPC_BL   = 3'b010;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;
   localparam logic [1:0] OP_B       = 2'b00;
   localparam logic [1:0] OP_BX      = 2'b00;
   localparam logic [1:0] OP_BLX     = 2'b10;
   localparam logic [1:0] OP_BL      = 2'b11;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_LE = 3'b100;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b100;

   localparam logic [3:0] VSEL_MDATA  = 4'b0001;
   localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
   localparam logic [3:0] VSEL_PC     = 4'b0100;
   localparam logic [3:0] VSEL_C      = 4'b1000;

   localparam logic [1:0] PC_SEL_INC = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_C   = 2'b10;

   typedef struct packed {
      logic [2:0] nsel;
      logic [3:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       load_ir;
      logic       load_pc;
      logic       reset_pc;
      logic [1:0] pc_sel;
      logic       addr_sel;
      logic       load_addr;
      logic [1:0] mem_cmd;
      logic       halted;
   } ctrl_out_t;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: cond field plus Z/N/V flags -> branch taken.
// Instantiated by cpu_controller only when CTRL_BRANCH_EN is defined.
module cond_eval
   import ctrl_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       z_flag,
   input  logic       n_flag,
   input  logic       v_flag,
   output logic       taken
);

   // Signed less-than is N!=V; less-or-equal adds Z.
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = z_flag;
         COND_NE: taken = ~z_flag;
         COND_LT: taken = n_flag ^ v_flag;
         COND_LE: taken = (n_flag ^ v_flag) | z_flag;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle Moore controller for the simple RISC datapath (fetch/decode/execute/writeback).
// Define CTRL_BRANCH_EN to add B/BL/BX/BLX sequencing; otherwise those opcodes are NOPs.
module cpu_controller
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] cond,
   input  logic       z_flag,
   input  logic       n_flag,
   input  logic       v_flag,
   output logic [2:0] nsel,
   output logic [3:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic [1:0] pc_sel,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic       halted
);

   state_t    state_q, state_d;
   ctrl_out_t out_q, out_d;

   logic is_mov_imm, is_mov_reg, is_mvn, is_alu_ab, is_cmp, is_ldr, is_str, is_halt;
   logic is_b, is_bl, is_bx, is_blx, br_taken;

   assign is_mov_imm = (opcode == OPC_MOV)  && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV)  && (op == OP_MOV_REG);
   assign is_mvn     = (opcode == OPC_ALU)  && (op == OP_MVN);
   assign is_alu_ab  = (opcode == OPC_ALU)  && ((op == OP_ADD) || (op == OP_AND));
   assign is_cmp     = (opcode == OPC_ALU)  && (op == OP_CMP);
   assign is_ldr     = (opcode == OPC_LDR)  && (op == OP_MEM);
   assign is_str     = (opcode == OPC_STR)  && (op == OP_MEM);
   assign is_halt    = (opcode == OPC_HALT);

`ifdef CTRL_BRANCH_EN
   assign is_b   = (opcode == OPC_B)  && (op == OP_B);
   assign is_bl  = (opcode == OPC_BL) && (op == OP_BL);
   assign is_bx  = (opcode == OPC_BL) && (op == OP_BX);
   assign is_blx = (opcode == OPC_BL) && (op == OP_BLX);

   cond_eval u_cond_eval (
      .cond   (cond),
      .z_flag (z_flag),
      .n_flag (n_flag),
      .v_flag (v_flag),
      .taken  (br_taken)
   );
`else
   logic unused_branch;
   assign is_b          = 1'b0;
   assign is_bl         = 1'b0;
   assign is_bx         = 1'b0;
   assign is_blx        = 1'b0;
   assign br_taken      = 1'b0;
   assign unused_branch = ^{cond, z_flag, n_flag, v_flag, is_b, is_bl, is_bx, is_blx, br_taken};
`endif

   function automatic ctrl_out_t decode_state(input state_t s);
      ctrl_out_t o;
      o = '0;
      case (s)
         S_RST:      begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
         S_IF1:      begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; end
         S_IF2:      begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; o.load_ir = 1'b1; end
         S_UPD_PC:   begin o.load_pc = 1'b1; o.pc_sel = PC_SEL_INC; end
         S_WR_IMM:   begin o.nsel = NSEL_RN; o.vsel = VSEL_SXIMM8; o.write = 1'b1; end
         S_GET_A:    begin o.nsel = NSEL_RN; o.loada = 1'b1; end
         S_GET_B:    begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
         // Single-operand ops share EXEC; force A to zero only for them.
         S_EXEC:     begin o.asel = is_mov_reg | is_mvn; o.loadc = 1'b1; end
         S_WR_REG:   begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
         S_EXEC_CMP: o.loads = 1'b1;
         S_MEM_ADDR: begin o.bsel = 1'b1; o.loadc = 1'b1; end
         S_LD_ADDR:  o.load_addr = 1'b1;
         S_MEM_RD:   o.mem_cmd = MEM_READ;
         S_MEM_WB:   begin o.mem_cmd = MEM_READ; o.nsel = NSEL_RD; o.vsel = VSEL_MDATA; o.write = 1'b1; end
         S_STR_RD:   begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
         S_STR_PASS: begin o.asel = 1'b1; o.loadc = 1'b1; end
         S_STR_WR:   o.mem_cmd = MEM_WRITE;
         S_HALT:     o.halted = 1'b1;
`ifdef CTRL_BRANCH_EN
         S_BR_TAKE:  begin o.load_pc = 1'b1; o.pc_sel = PC_SEL_BR; end
         S_BL_LINK:  begin o.nsel = NSEL_RN; o.vsel = VSEL_PC; o.write = 1'b1; end
         S_BX_GET:   begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
         S_BX_PASS:  begin o.asel = 1'b1; o.loadc = 1'b1; end
         S_BX_LOAD:  begin o.load_pc = 1'b1; o.pc_sel = PC_SEL_C; end
`endif
         default:    o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:      state_d = S_IF1;
         S_IF1:      state_d = S_IF2;
         S_IF2:      state_d = S_UPD_PC;
         S_UPD_PC:   state_d = S_DECODE;
         S_DECODE: begin
            if (is_mov_imm)                                        state_d = S_WR_IMM;
            else if (is_mov_reg || is_mvn)                         state_d = S_GET_B;
            else if (is_alu_ab || is_cmp || is_ldr || is_str)      state_d = S_GET_A;
            else if (is_halt)                                      state_d = S_HALT;
            else if (is_b)                                         state_d = br_taken ? S_BR_TAKE : S_IF1;
            else if (is_bl)                                        state_d = S_BL_LINK;
            else if (is_bx || is_blx)                              state_d = S_BX_GET;
            else                                                   state_d = S_IF1;
         end
         S_WR_IMM:   state_d = S_IF1;
         S_GET_A:    state_d = (is_ldr || is_str) ? S_MEM_ADDR : S_GET_B;
         S_GET_B:    state_d = is_cmp ? S_EXEC_CMP : S_EXEC;
         S_EXEC:     state_d = S_WR_REG;
         S_WR_REG:   state_d = S_IF1;
         S_EXEC_CMP: state_d = S_IF1;
         S_MEM_ADDR: state_d = S_LD_ADDR;
         S_LD_ADDR:  state_d = is_str ? S_STR_RD : S_MEM_RD;
         S_MEM_RD:   state_d = S_MEM_WB;
         S_MEM_WB:   state_d = S_IF1;
         S_STR_RD:   state_d = S_STR_PASS;
         S_STR_PASS: state_d = S_STR_WR;
         S_STR_WR:   state_d = S_IF1;
         S_HALT:     state_d = S_HALT;
`ifdef CTRL_BRANCH_EN
         S_BR_TAKE:  state_d = S_IF1;
         // BLX reads Rd in BX_GET before BL_LINK overwrites R7.
         S_BL_LINK:  state_d = is_blx ? S_BX_PASS : S_BR_TAKE;
         S_BX_GET:   state_d = is_blx ? S_BL_LINK : S_BX_PASS;
         S_BX_PASS:  state_d = S_BX_LOAD;
         S_BX_LOAD:  state_d = S_IF1;
`endif
         default:    state_d = S_RST;
      endcase
   end

   // Strobes are decoded from the next state so they leave a flop aligned with state_q.
   always_comb begin
      out_d = decode_state(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RST;
         out_q   <= decode_state(S_RST);
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign nsel      = out_q.nsel;
   assign vsel      = out_q.vsel;
   assign write     = out_q.write;
   assign loada     = out_q.loada;
   assign loadb     = out_q.loadb;
   assign loadc     = out_q.loadc;
   assign loads     = out_q.loads;
   assign asel      = out_q.asel;
   assign bsel      = out_q.bsel;
   assign load_ir   = out_q.load_ir;
   assign load_pc   = out_q.load_pc;
   assign reset_pc  = out_q.reset_pc;
   assign pc_sel    = out_q.pc_sel;
   assign addr_sel  = out_q.addr_sel;
   assign load_addr = out_q.load_addr;
   assign mem_cmd   = out_q.mem_cmd;
   assign halted    = out_q.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: table of per-instruction latency/strobe counts
// plus hand-written sequences for reset, MOV, ADD, STR abort, HALT and branches.
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] cond;
   logic       z_flag, n_flag, v_flag;
   logic [2:0] nsel;
   logic [3:0] vsel;
   logic       write, loada, loadb, loadc, loads, asel, bsel;
   logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;
   logic [1:0] pc_sel, mem_cmd;

   cpu_controller dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op), .cond(cond),
      .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag),
      .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .load_ir(load_ir),
      .load_pc(load_pc), .reset_pc(reset_pc), .pc_sel(pc_sel), .addr_sel(addr_sel),
      .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [23:0] outs;
   assign outs = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                  load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr, mem_cmd, halted};

   // Packed output vectors: nsel[23:21] vsel[20:17] write[16] loada[15] loadb[14] loadc[13]
   // loads[12] asel[11] bsel[10] load_ir[9] load_pc[8] reset_pc[7] pc_sel[6:5] addr_sel[4]
   // load_addr[3] mem_cmd[2:1] halted[0]
   localparam logic [23:0] EV_RST      = 24'h000180;
   localparam logic [23:0] EV_IF1      = 24'h000012;
   localparam logic [23:0] EV_HALT     = 24'h000001;
   localparam logic [23:0] EV_WR_IMM   = 24'h250000;
   localparam logic [23:0] EV_GET_A    = 24'h208000;
   localparam logic [23:0] EV_GET_B    = 24'h804000;
   localparam logic [23:0] EV_EXEC_AB  = 24'h002000;
   localparam logic [23:0] EV_WR_REG   = 24'h510000;
   localparam logic [23:0] EV_STR_PASS = 24'h002800;
   localparam logic [23:0] EV_BR_TAKE  = 24'h000120;

   typedef struct {
      logic [2:0] opc;
      logic [1:0] opv;
      int         len;
      int         n_write;
      int         n_loads;
      int         n_memwr;
      int         n_loadc;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   int   memwr_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (mem_cmd == 2'b10) memwr_seen++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic bit at_if1();
      return (mem_cmd == 2'b01) && addr_sel && !load_ir;
   endfunction

   // Starts sampled in IF1; returns when the next IF1 is seen (or after a cycle budget).
   task automatic run_instr(input logic [2:0] opc, input logic [1:0] opv,
                            output int len, output int nw, output int ns,
                            output int nm, output int nc);
      opcode = opc;
      op     = opv;
      len = 1; nw = 0; ns = 0; nm = 0; nc = 0;
      while (len < 60) begin
         step();
         if (at_if1()) break;
         len++;
         nw += int'(write);
         ns += int'(loads);
         nm += int'(mem_cmd == 2'b10);
         nc += int'(loadc);
      end
   endtask

   initial begin
      int len, nw, ns, nm, nc, wr_before;
      bit halt_ok;
      vecs.push_back('{3'b110, 2'b10, 5,  1, 0, 0, 0});
      vecs.push_back('{3'b110, 2'b00, 7,  1, 0, 0, 1});
      vecs.push_back('{3'b101, 2'b11, 7,  1, 0, 0, 1});
      vecs.push_back('{3'b101, 2'b00, 8,  1, 0, 0, 1});
      vecs.push_back('{3'b101, 2'b10, 8,  1, 0, 0, 1});
      vecs.push_back('{3'b101, 2'b01, 7,  0, 1, 0, 0});
      vecs.push_back('{3'b011, 2'b00, 9,  1, 0, 0, 1});
      vecs.push_back('{3'b100, 2'b00, 10, 0, 0, 1, 2});
      vecs.push_back('{3'b000, 2'b00, 4,  0, 0, 0, 0});
      vecs.push_back('{3'b110, 2'b01, 4,  0, 0, 0, 0});
      vecs.push_back('{3'b011, 2'b01, 4,  0, 0, 0, 0});
      vecs.push_back('{3'b100, 2'b11, 4,  0, 0, 0, 0});
`ifndef CTRL_BRANCH_EN
      vecs.push_back('{3'b001, 2'b00, 4,  0, 0, 0, 0});
      vecs.push_back('{3'b010, 2'b11, 4,  0, 0, 0, 0});
      vecs.push_back('{3'b010, 2'b00, 4,  0, 0, 0, 0});
`endif

      rst_n = 1'b0; opcode = 3'b000; op = 2'b00; cond = 3'b000;
      z_flag = 1'b0; n_flag = 1'b0; v_flag = 1'b0;

      step();
      chk("rst_hold1", 32'(outs), 32'(EV_RST));
      step();
      chk("rst_hold2", 32'(outs), 32'(EV_RST));
      rst_n = 1'b1;
      step();
      chk("rst_release_if1", 32'(outs), 32'(EV_IF1));

      foreach (vecs[k]) begin
         run_instr(vecs[k].opc, vecs[k].opv, len, nw, ns, nm, nc);
         chk($sformatf("len_%b_%b", vecs[k].opc, vecs[k].opv), 32'(len), 32'(vecs[k].len));
         chk($sformatf("writes_%b_%b", vecs[k].opc, vecs[k].opv), 32'(nw), 32'(vecs[k].n_write));
         chk($sformatf("loads_%b_%b", vecs[k].opc, vecs[k].opv), 32'(ns), 32'(vecs[k].n_loads));
         chk($sformatf("memwr_%b_%b", vecs[k].opc, vecs[k].opv), 32'(nm), 32'(vecs[k].n_memwr));
         chk($sformatf("loadc_%b_%b", vecs[k].opc, vecs[k].opv), 32'(nc), 32'(vecs[k].n_loadc));
      end

      // MOV R0,#5
      opcode = 3'b110; op = 2'b10;
      steps(4);
      chk("mov_imm_wr", 32'(outs), 32'(EV_WR_IMM));
      step();
      chk("mov_imm_next_if1", 32'(outs), 32'(EV_IF1));

      // ADD: A, B, C loads then writeback
      opcode = 3'b101; op = 2'b00;
      steps(4);
      chk("add_get_a", 32'(outs), 32'(EV_GET_A));
      step();
      chk("add_get_b", 32'(outs), 32'(EV_GET_B));
      step();
      chk("add_exec", 32'(outs), 32'(EV_EXEC_AB));
      step();
      chk("add_wr_reg", 32'(outs), 32'(EV_WR_REG));
      step();
      chk("add_next_if1", 32'(outs), 32'(EV_IF1));

      // STR aborted by reset in STR_PASS
      opcode = 3'b100; op = 2'b00;
      wr_before = memwr_seen;
      steps(8);
      chk("str_pass", 32'(outs), 32'(EV_STR_PASS));
      rst_n = 1'b0;
      step();
      chk("str_abort_rst", 32'(outs), 32'(EV_RST));
      steps(2);
      chk("str_abort_no_write", 32'(memwr_seen - wr_before), 32'd0);
      rst_n = 1'b1;
      step();
      chk("str_abort_if1", 32'(outs), 32'(EV_IF1));

      // HALT holds until reset
      opcode = 3'b111; op = 2'b01;
      steps(4);
      chk("halt_enter", 32'(outs), 32'(EV_HALT));
      halt_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (outs !== EV_HALT) halt_ok = 1'b0;
      end
      chk("halt_held_20", 32'(halt_ok), 32'd1);
      rst_n = 1'b0;
      step();
      chk("halt_cleared", 32'(outs), 32'(EV_RST));
      rst_n = 1'b1;
      step();
      chk("halt_reset_if1", 32'(outs), 32'(EV_IF1));

`ifdef CTRL_BRANCH_EN
      // BEQ taken then not taken
      opcode = 3'b001; op = 2'b00; cond = 3'b001; z_flag = 1'b1;
      steps(4);
      chk("beq_taken", 32'(outs), 32'(EV_BR_TAKE));
      step();
      chk("beq_taken_if1", 32'(outs), 32'(EV_IF1));
      z_flag = 1'b0;
      steps(4);
      chk("beq_not_taken_if1", 32'(outs), 32'(EV_IF1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
